// File: rtl/serial_shifter_if.sv
// rtl/serial_shifter_if.sv - request/result handshake bundle for serial_shifter
interface serial_shifter_if #(
  parameter int D_SIZE = 8
);
  logic                      valid_in;
  logic                      ready_out;
  logic [D_SIZE-1:0]         x_in;
  logic [$clog2(D_SIZE)-1:0] s_in;
  logic [2:0]                op_in;
  logic                      valid_out;
  logic                      ready_in;
  logic [D_SIZE-1:0]         y_out;
  logic                      zf_out;
  logic                      vf_out;

  modport slave (
    input  valid_in, x_in, s_in, op_in, ready_in,
    output ready_out, valid_out, y_out, zf_out, vf_out
  );

  modport master (
    output valid_in, x_in, s_in, op_in, ready_in,
    input  ready_out, valid_out, y_out, zf_out, vf_out
  );
endinterface

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - multi-cycle shifter/rotator, one bit position per clock
module serial_shifter #(
  parameter int D_SIZE = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  serial_shifter_if.slave   bus
);
  localparam int CW = $clog2(D_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [D_SIZE-1:0] work_q;
  logic [2:0]        op_q;
  logic [CW-1:0]     cnt_q;
  logic              zf_q;
  logic              vf_q;
  logic              ready_q;
  logic              valid_q;
  logic [D_SIZE-1:0] work_d;
  logic              sla_ovf_d;

  // op[2] selects left, op[1] selects rotate, op[0] selects arithmetic for plain shifts
  function automatic logic [D_SIZE-1:0] shift_step(input logic [D_SIZE-1:0] x,
                                                    input logic [2:0] op);
    logic [D_SIZE-1:0] r;
    r = x;
    case (op[2:1])
      2'b00:   r = op[0] ? {x[D_SIZE-1], x[D_SIZE-1:1]} : {1'b0, x[D_SIZE-1:1]};
      2'b01:   r = {x[0], x[D_SIZE-1:1]};
      2'b10:   r = op[0] ? {x[D_SIZE-1], x[D_SIZE-3:0], 1'b0} : {x[D_SIZE-2:0], 1'b0};
      default: r = {x[D_SIZE-2:0], x[D_SIZE-1]};
    endcase
    return r;
  endfunction

  always_comb begin
    work_d    = shift_step(work_q, op_q);
    sla_ovf_d = (op_q == 3'b101) && (work_q[D_SIZE-2] != work_q[D_SIZE-1]);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      work_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      zf_q    <= 1'b0;
      vf_q    <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_in) begin
            work_q  <= bus.x_in;
            op_q    <= bus.op_in;
            cnt_q   <= bus.s_in;
            zf_q    <= (bus.x_in == '0);
            vf_q    <= 1'b0;
            ready_q <= 1'b0;
            if (bus.s_in == '0) begin
              state_q <= DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_q <= work_d;
          zf_q   <= (work_d == '0);
          cnt_q  <= cnt_q - CW'(1);
          if (sla_ovf_d) vf_q <= 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          // result and flags hold here for as long as the consumer stalls
          if (bus.ready_in) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_out = ready_q;
  assign bus.valid_out = valid_q;
  assign bus.y_out     = work_q;
  assign bus.zf_out    = zf_q;
  assign bus.vf_out    = vf_q;
endmodule

// File: tb/tb_serial_shifter.sv
// tb/tb_serial_shifter.sv - directed self-checking bench for serial_shifter (D_SIZE=8)
module tb_serial_shifter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_shifter_if #(.D_SIZE(8)) bus ();

  serial_shifter #(.D_SIZE(8)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request; inputs are scrambled while busy to prove they are ignored.
  task automatic run_op(input string tag, input logic [7:0] x, input logic [2:0] s,
                        input logic [2:0] op, input logic [7:0] ey, input logic ezf,
                        input logic evf, input int hold);
    int lat;
    check({tag, "_ready"}, {31'd0, bus.ready_out}, 32'd1);
    bus.valid_in = 1'b1;
    bus.x_in     = x;
    bus.s_in     = s;
    bus.op_in    = op;
    bus.ready_in = 1'b0;
    tick();
    bus.x_in  = ~x;
    bus.s_in  = 3'd1;
    bus.op_in = ~op;
    lat = 0;
    while (!bus.valid_out && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, {29'd0, s});
    check({tag, "_y"},  {24'd0, bus.y_out}, {24'd0, ey});
    check({tag, "_zf"}, {31'd0, bus.zf_out}, {31'd0, ezf});
    check({tag, "_vf"}, {31'd0, bus.vf_out}, {31'd0, evf});
    for (int i = 0; i < hold; i++) begin
      bus.x_in = 8'(i * 37 + 5);
      tick();
      check({tag, "_hold_v"}, {31'd0, bus.valid_out}, 32'd1);
      check({tag, "_hold_y"}, {24'd0, bus.y_out}, {24'd0, ey});
      check({tag, "_hold_f"}, {30'd0, bus.zf_out, bus.vf_out}, {30'd0, ezf, evf});
    end
    bus.ready_in = 1'b1;
    tick();
    check({tag, "_idle_r"}, {31'd0, bus.ready_out}, 32'd1);
    check({tag, "_idle_v"}, {31'd0, bus.valid_out}, 32'd0);
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    tick();
  endtask

  initial begin
    int seen;
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.x_in     = 8'h00;
    bus.s_in     = 3'd0;
    bus.op_in    = 3'b000;
    bus.ready_in = 1'b0;
    tick();
    check("rst_ready", {31'd0, bus.ready_out}, 32'd1);
    check("rst_valid", {31'd0, bus.valid_out}, 32'd0);
    check("rst_y",     {24'd0, bus.y_out}, 32'd0);
    check("rst_flags", {30'd0, bus.zf_out, bus.vf_out}, 32'd0);
    tick();
    rst_n = 1'b1;

    run_op("srl_b4",   8'hB4, 3'd3, 3'b000, 8'h16, 1'b0, 1'b0, 5);
    run_op("sra_80",   8'h80, 3'd7, 3'b001, 8'hFF, 1'b0, 1'b0, 0);
    run_op("sra_74",   8'h74, 3'd2, 3'b001, 8'h1D, 1'b0, 1'b0, 1);
    run_op("rol_110",  8'h81, 3'd1, 3'b110, 8'h03, 1'b0, 1'b0, 0);
    run_op("rol_111",  8'h81, 3'd1, 3'b111, 8'h03, 1'b0, 1'b0, 0);
    run_op("ror_010",  8'h01, 3'd1, 3'b010, 8'h80, 1'b0, 1'b0, 0);
    run_op("ror_011",  8'h01, 3'd1, 3'b011, 8'h80, 1'b0, 1'b0, 0);
    run_op("ror_b4",   8'hB4, 3'd3, 3'b010, 8'h96, 1'b0, 1'b0, 0);
    run_op("sla_20",   8'h20, 3'd2, 3'b101, 8'h00, 1'b1, 1'b1, 0);
    run_op("sla_c0",   8'hC0, 3'd1, 3'b101, 8'h80, 1'b0, 1'b0, 0);
    run_op("sla_13",   8'h13, 3'd3, 3'b101, 8'h18, 1'b0, 1'b1, 0);
    run_op("sll_5a",   8'h5A, 3'd4, 3'b100, 8'hA0, 1'b0, 1'b0, 0);
    run_op("sll_zero", 8'h00, 3'd0, 3'b100, 8'h00, 1'b1, 1'b0, 3);

    bus.valid_in = 1'b1;
    bus.x_in     = 8'hFF;
    bus.s_in     = 3'd7;
    bus.op_in    = 3'b000;
    tick();
    bus.valid_in = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, bus.ready_out}, 32'd1);
    check("abort_valid", {31'd0, bus.valid_out}, 32'd0);
    check("abort_y",     {24'd0, bus.y_out}, 32'd0);
    check("abort_flags", {30'd0, bus.zf_out, bus.vf_out}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.valid_out) seen++;
    end
    check("abort_no_valid", seen, 32'd0);
    run_op("post_rst", 8'hFF, 3'd7, 3'b000, 8'h01, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_shifter.md
SERIAL_SHIFTER -- requirements
Module: serial_shifter

Interface
REQ-001: Parameter D_SIZE, default 8, data width; SHALL be a power of 2, >= 4.
REQ-002: clk_in  input  1  single clock; all state updates on the rising edge.
REQ-003: rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-004: valid_in  input  1  request valid.
REQ-005: ready_out  output  1  block can accept a request.
REQ-006: x_in  input  D_SIZE  operand.
REQ-007: s_in  input  $clog2(D_SIZE)  shift amount, 0..D_SIZE-1.
REQ-008: op_in  input  3  operation: 000 SRL, 001 SRA, 01x ROR, 100 SLL, 101 SLA, 11x ROL.
REQ-009: valid_out  output  1  result valid.
REQ-010: ready_in  input  1  downstream accepts result.
REQ-011: y_out  output  D_SIZE  result, registered.
REQ-012: zf_out  output  1  y_out is all zeros, registered.
REQ-013: vf_out  output  1  SLA overflow, registered.

Function
REQ-014: FSM states IDLE, SHIFT, DONE; ready_out SHALL be 1 only in IDLE; valid_out SHALL be 1 only in DONE.
REQ-015: Acceptance: rising edge with state IDLE and valid_in=1; latches x_in, op_in, s_in into working register, op register and down-counter; clears vf.
REQ-016: On acceptance with s_in=0 -> DONE; otherwise -> SHIFT with counter = s_in.
REQ-017: Each edge in SHIFT: one 1-bit step on the working register, counter decrements; step taken with counter=1 moves to DONE.
REQ-018: valid_out SHALL rise after exactly max(s_in,0) further edges following acceptance (s_in=0: cycle right after acceptance; s_in=k: k edges later).
REQ-019: 1-bit steps: SRL {0,x[D-1:1]}; SRA {x[D-1],x[D-1:1]}; ROR {x[0],x[D-1:1]}; SLL {x[D-2:0],0}; SLA {x[D-1],x[D-3:0],0}; ROL {x[D-2:0],x[D-1]}.
REQ-020: Final result after s steps SHALL equal the single-cycle definition: SRL x>>s, SRA signed x>>>s, ROR/ROL rotate by s mod D_SIZE, SLL x<<s, SLA (x<<s with bit D-1 replaced by original x[D-1]).
REQ-021: vf: during each SLA step, if x[D-2] != x[D-1] before the step, vf SHALL set; sticky until next acceptance; always 0 for other ops.
REQ-022: y_out SHALL reflect the working register; zf_out = (working register == 0); both valid whenever valid_out=1.
REQ-023: Intermediate y_out/zf_out values during SHIFT are don't-care for the consumer (valid_out=0).
REQ-024: DONE: y_out, zf_out, vf_out SHALL stay stable while ready_in=0 (backpressure, unbounded).
REQ-025: DONE with ready_in=1 at an edge -> IDLE; no request accepted on that same edge; next request accepted earliest one cycle later.
REQ-026: valid_in and operand changes while state != IDLE SHALL be ignored and SHALL not disturb the operation in progress.
REQ-027: op_in 01x and 11x SHALL ignore the LSB; no op encoding is illegal.

Reset
REQ-028: rst_n_in=0 SHALL immediately force state IDLE, y_out=0, zf_out=0, vf_out=0, valid_out=0, counter=0; ready_out=1 while in reset and after.
REQ-029: Reset asserted in SHIFT or DONE SHALL abort the operation; no valid_out for the aborted request at any time after reset release.
REQ-030: First acceptance possible on the first rising edge after rst_n_in deasserts.

Verification (D_SIZE=8)
REQ-031: SRL x=8'hB4 s=3, ready_in held low 5 cycles after valid_out -> valid_out 3 edges after acceptance, y=8'h16 zf=0 vf=0, stable through backpressure, IDLE one cycle after ready_in=1.
REQ-032: SRA x=8'h80 s=7 -> y=8'hFF zf=0 vf=0, valid_out 7 edges after acceptance.
REQ-033: ROL x=8'h81 s=1 -> y=8'h03; ROR x=8'h01 s=1 -> y=8'h80; op 3'b011 and 3'b111 give same results as 010/110.
REQ-034: SLA x=8'h20 s=2 -> y=8'h00 zf=1 vf=1; SLA x=8'hC0 s=1 -> y=8'h80 vf=0.
REQ-035: SLL x=8'h00 s=0 -> valid_out in cycle after acceptance, y=8'h00 zf=1; valid_in pulsed with other operands during DONE -> ignored, result unchanged.
REQ-036: Accept SRL s=7, assert rst_n_in=0 after 3 cycles -> outputs zero immediately, ready_out=1, no valid_out after release; new request then completes correctly.
